// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter sharing one serial transmitter among four requesters.
// Launches a one-cycle start with the winner's payload, then blocks for the frame window.
`timescale 1ns/1ps
module serial_tx_arbiter #(
  parameter int GAP_CYCLES = 10
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_en,
  input  logic [3:0]  i_req,
  input  logic [27:0] i_req_data,
  output logic        o_tx_start,
  output logic [6:0]  o_tx_data,
  output logic [3:0]  o_ack,
  output logic [1:0]  o_owner,
  output logic        o_busy
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic [1:0] r_ptr, w_ptr_nxt;
  logic [1:0] w_win;
  logic       w_hit;
  logic [6:0] w_slot [4];
  logic       w_start_nxt, w_busy_nxt;
  logic [3:0] w_ack_nxt;
  logic [6:0] w_data_nxt;
  logic [1:0] w_owner_nxt;

  always_comb begin
    for (int i = 0; i < 4; i++) w_slot[i] = i_req_data[7*i +: 7];
  end

  // Search ptr+1 .. ptr+4; iterating downward lets the nearest candidate win.
  always_comb begin
    logic [1:0] idx;
    w_hit = 1'b0;
    w_win = r_ptr;
    for (int k = 4; k >= 1; k--) begin
      idx = r_ptr + 2'(k);
      if (i_req[idx]) begin
        w_hit = 1'b1;
        w_win = idx;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ptr_nxt   = r_ptr;
    w_start_nxt = 1'b0;
    w_ack_nxt   = 4'b0000;
    w_data_nxt  = o_tx_data;
    w_owner_nxt = o_owner;
    w_busy_nxt  = o_busy;
    case (r_state)
      S_IDLE: begin
        w_busy_nxt = 1'b0;
        if (i_en && w_hit) begin
          w_start_nxt = 1'b1;
          w_ack_nxt   = 4'b0001 << w_win;
          w_data_nxt  = w_slot[w_win];
          w_owner_nxt = w_win;
          w_ptr_nxt   = w_win;
          w_cnt_nxt   = 8'(GAP_CYCLES - 1);
          w_state_nxt = S_WAIT;
          w_busy_nxt  = 1'b1;
        end
      end
      S_WAIT: begin
        w_busy_nxt = 1'b1;
        if (r_cnt == 8'd0) begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Pointer resets to 3 so requester 0 has first priority.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state    <= S_IDLE;
      r_cnt      <= 8'd0;
      r_ptr      <= 2'd3;
      o_tx_start <= 1'b0;
      o_tx_data  <= 7'd0;
      o_ack      <= 4'd0;
      o_owner    <= 2'd0;
      o_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_ptr      <= w_ptr_nxt;
      o_tx_start <= w_start_nxt;
      o_tx_data  <= w_data_nxt;
      o_ack      <= w_ack_nxt;
      o_owner    <= w_owner_nxt;
      o_busy     <= w_busy_nxt;
    end
  end

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Scoreboard bench for serial_tx_arbiter: expected grants queued at stimulus, checked at launch.
`timescale 1ns/1ps
module tb_serial_tx_arbiter;
  localparam int GAP = 10;

  logic        clk = 1'b0, rstn = 1'b0, en = 1'b0;
  logic [3:0]  req = 4'd0;
  logic [27:0] req_data = 28'd0;
  logic        tx_start, busy;
  logic [6:0]  tx_data;
  logic [3:0]  ack;
  logic [1:0]  owner;

  serial_tx_arbiter #(.GAP_CYCLES(GAP)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_en(en), .i_req(req), .i_req_data(req_data),
    .o_tx_start(tx_start), .o_tx_data(tx_data), .o_ack(ack), .o_owner(owner), .o_busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {logic [1:0] own; logic [6:0] dat;} exp_t;
  exp_t sb[$];
  int n_checks = 0, n_fail = 0;
  int prev_start = -1000;

  task automatic set_slot(input int i, input logic [6:0] d);
    req_data[7*i +: 7] = d;
  endtask

  task automatic push_exp(input logic [1:0] o, input logic [6:0] d);
    exp_t e;
    e.own = o; e.dat = d;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rstn = 1'b0; req = 4'd0; en = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  // Waits up to max_cyc negedges for a launch and checks it against the scoreboard head.
  task automatic wait_launch(input int max_cyc, input bit spaced, input string tag);
    int n = 0;
    bit seen = 1'b0;
    exp_t e;
    while (!seen && n < max_cyc) begin
      @(negedge clk);
      n++;
      if (tx_start === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s launch: no tx_start within %0d cycles", tag, max_cyc);
      return;
    end
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s unexpected launch: owner=%0d data=%h", tag, owner, tx_data);
      return;
    end
    e = sb.pop_front();
    n_checks++;
    if (ack !== (4'b0001 << e.own)) begin
      n_fail++; $display("FAIL %s ack: got %b want %b", tag, ack, 4'b0001 << e.own);
    end
    n_checks++;
    if (tx_data !== e.dat) begin
      n_fail++; $display("FAIL %s tx_data: got %h want %h", tag, tx_data, e.dat);
    end
    n_checks++;
    if (owner !== e.own) begin
      n_fail++; $display("FAIL %s owner: got %0d want %0d", tag, owner, e.own);
    end
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL %s busy_at_start: got %b want 1", tag, busy);
    end
    if (spaced) begin
      n_checks++;
      if (cyc - prev_start != GAP + 1) begin
        n_fail++; $display("FAIL %s spacing: got %0d want %0d", tag, cyc - prev_start, GAP + 1);
      end
    end
    prev_start = cyc;
  endtask

  // Counts busy cycles starting at the launch cycle.
  task automatic count_busy(output int nb);
    nb = 0;
    while (busy === 1'b1 && nb < 300) begin
      nb++;
      @(negedge clk);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    n_checks++;
    if (tx_start !== 1'b0 || tx_data !== 7'd0 || ack !== 4'd0 || owner !== 2'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s outputs: got start=%b data=%h ack=%b owner=%0d busy=%b want all 0",
               tag, tx_start, tx_data, ack, owner, busy);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    @(negedge clk);
    check_outputs_zero("reset");
    rstn = 1'b1;
  endtask

  task automatic test_single();
    int nb;
    do_reset();
    en = 1'b1;
    set_slot(1, 7'h55);
    req = 4'b0010;
    push_exp(2'd1, 7'h55);
    wait_launch(1, 1'b0, "single");
    req = 4'd0;
    count_busy(nb);
    n_checks++;
    if (nb != GAP) begin
      n_fail++; $display("FAIL single busy_len: got %0d want %0d", nb, GAP);
    end
    n_checks++;
    if (tx_data !== 7'h55) begin
      n_fail++; $display("FAIL single data_hold: got %h want 55", tx_data);
    end
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (tx_start !== 1'b0 || ack !== 4'd0) begin
        n_fail++; $display("FAIL single idle_quiet: got start=%b ack=%b want 0", tx_start, ack);
      end
    end
  endtask

  task automatic test_all_four();
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_slot(i, 7'(i + 1));
      push_exp(2'(i), 7'(i + 1));
    end
    req = 4'b1111;
    wait_launch(1, 1'b0, "all4_0");
    req[0] = 1'b0;
    for (int i = 1; i < 4; i++) begin
      wait_launch(GAP + 1, 1'b1, "all4");
      req[i] = 1'b0;
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    en = 1'b1;
    set_slot(2, 7'h2A);
    req = 4'b0100;
    push_exp(2'd2, 7'h2A);
    wait_launch(1, 1'b0, "rr_2");
    set_slot(0, 7'h10);
    set_slot(3, 7'h33);
    req = 4'b1001;
    push_exp(2'd3, 7'h33);
    push_exp(2'd0, 7'h10);
    wait_launch(GAP + 1, 1'b1, "rr_3");
    req[3] = 1'b0;
    wait_launch(GAP + 1, 1'b1, "rr_0");
    req = 4'd0;
  endtask

  task automatic test_enable();
    int nb;
    do_reset();
    en = 1'b0;
    set_slot(0, 7'h47);
    set_slot(1, 7'h19);
    req = 4'b0001;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++;
      if (tx_start !== 1'b0 || ack !== 4'd0) begin
        n_fail++; $display("FAIL en_low cycle %0d: got start=%b ack=%b want 0", i, tx_start, ack);
      end
    end
    en = 1'b1;
    push_exp(2'd0, 7'h47);
    wait_launch(1, 1'b0, "en_rise");
    en = 1'b0;
    req = 4'b1110;
    count_busy(nb);
    n_checks++;
    if (nb != GAP) begin
      n_fail++; $display("FAIL wait_ignore busy_len: got %0d want %0d", nb, GAP);
    end
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      n_checks++;
      if (tx_start !== 1'b0) begin
        n_fail++; $display("FAIL wait_ignore extra_launch cycle %0d: got %b want 0", i, tx_start);
      end
    end
    en = 1'b1;
    push_exp(2'd1, 7'h19);
    wait_launch(1, 1'b0, "en_reenable");
    req = 4'd0;
    count_busy(nb);
  endtask

  task automatic test_reset_mid();
    do_reset();
    en = 1'b1;
    set_slot(0, 7'h0F);
    set_slot(3, 7'h7E);
    req = 4'b0001;
    push_exp(2'd0, 7'h0F);
    wait_launch(1, 1'b0, "rst_pre");
    req = 4'b1001;
    repeat (4) @(negedge clk);
    rstn = 1'b0;
    #1;
    check_outputs_zero("rst_mid");
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    // Pointer restarted: requester 0 wins the tie against 3.
    push_exp(2'd0, 7'h0F);
    wait_launch(1, 1'b0, "rst_tie");
    req = 4'b1000;
    push_exp(2'd3, 7'h7E);
    wait_launch(GAP + 1, 1'b1, "rst_after_tie");
    repeat (4) @(negedge clk);
    rstn = 1'b0;
    #1;
    check_outputs_zero("rst_mid2");
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    push_exp(2'd3, 7'h7E);
    wait_launch(1, 1'b0, "rst_pending3");
    req = 4'd0;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_empty: got %0d pending want 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_round_robin();
    test_enable();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
